// File: rtl/spy_readout.sv
// spy_readout: readout sequencer for the spy buffer.
// Freezes the spy buffer, snapshots its write pointers, looks up the start of
// the oldest requested event in the event list, then streams spy memory from
// there up to the frozen write pointer on a valid/ready interface.
// Optional feature: define SPY_READOUT_HEADER_EN to prefix each dump with one
// header word {num_events, start address, count} flagged by bit DATA_WIDTH.
module spy_readout #(
  parameter int DATA_WIDTH    = 64,
  parameter int SPY_MEM_WIDTH = 7,
  parameter int EL_MEM_WIDTH  = 4
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     start,
  input  logic [EL_MEM_WIDTH-1:0]  num_events,
  output logic                     freeze,
  input  logic [SPY_MEM_WIDTH-1:0] spy_write_addr,
  input  logic [EL_MEM_WIDTH-1:0]  spy_meta_write_addr,
  output logic                     spy_meta_read_enable,
  output logic [EL_MEM_WIDTH-1:0]  spy_meta_read_addr,
  input  logic [SPY_MEM_WIDTH:0]   spy_meta_read_data,
  output logic                     spy_read_enable,
  output logic [SPY_MEM_WIDTH-1:0] spy_read_addr,
  input  logic [DATA_WIDTH:0]      spy_data,
  output logic [DATA_WIDTH:0]      m_data,
  output logic                     m_valid,
  input  logic                     m_ready,
  output logic                     m_last,
  output logic                     busy,
  output logic                     done
);
  localparam int SW  = SPY_MEM_WIDTH;
  localparam int DW1 = DATA_WIDTH + 1;
  localparam logic [SW-1:0] RD_ONE   = {{(SW-1){1'b0}}, 1'b1};
  localparam logic [SW:0]   CNT_ONE  = {{SW{1'b0}}, 1'b1};
  localparam logic [SW:0]   CNT_FULL = {1'b1, {SW{1'b0}}};

  typedef enum logic [2:0] {
    S_IDLE, S_FREEZE, S_SNAP, S_META, S_STREAM, S_DONE
  } state_t;

  state_t state, state_nxt;

  logic [EL_MEM_WIDTH-1:0] n_q;
  logic [SW-1:0]           wp_q;
  logic [SW-1:0]           rd;
  logic [SW:0]             count;
  logic                    rvld;    // spy_data carries a word this cycle
  logic                    rlast;   // ... and it is the final word
  logic [1:0][DW1-1:0]     buf_q;   // skid buffer, entry 0 is the head
  logic [1:0]              bl_q;
  logic [1:0]              cnt;
  logic [1:0][DW1-1:0]     buf_n;
  logic [1:0]              bl_n;
  logic [1:0]              cnt_n;

  logic [SW-1:0] meta_rd;
  logic [SW:0]   meta_count;
  logic [SW-1:0] meta_diff;
  logic          issue, pop, fifo_pop, in_vld, in_last, last_hs, hdr_push;
  logic [DW1-1:0] in_data, hdr;

  // Start address and length of the dump from the returned event-list entry
  always_comb begin
    meta_diff = wp_q - spy_meta_read_data[SW-1:0];
    if (spy_meta_read_data[SW]) begin
      meta_rd    = spy_meta_read_data[SW-1:0];
      meta_count = (meta_diff == '0) ? CNT_FULL : {1'b0, meta_diff};
    end else begin
      meta_rd    = wp_q;
      meta_count = CNT_FULL;
    end
  end

`ifdef SPY_READOUT_HEADER_EN
  localparam int HW = EL_MEM_WIDTH + SW + SW + 1;
  // Header word pushed into the skid buffer as META exits
  always_comb begin
    hdr             = '0;
    hdr[DATA_WIDTH] = 1'b1;
    hdr[HW-1:0]     = {n_q, meta_rd, meta_count};
  end
  assign hdr_push = (state == S_META);
`else
  assign hdr      = '0;
  assign hdr_push = 1'b0;
`endif

  // Output stage: head of the skid buffer, or the memory word passing straight through
  always_comb begin
    m_valid = (cnt != 2'd0) | rvld;
    m_data  = '0;
    m_last  = 1'b0;
    if (cnt != 2'd0) begin
      m_data = buf_q[0];
      m_last = bl_q[0];
    end else if (rvld) begin
      m_data = spy_data;
      m_last = rlast;
    end
    pop      = m_valid & m_ready;
    fifo_pop = pop & (cnt != 2'd0);
    last_hs  = pop & m_last;
    // A returning word is buffered unless it was consumed in the bypass
    in_vld   = (rvld & ~(pop & (cnt == 2'd0))) | hdr_push;
    in_data  = hdr_push ? hdr : spy_data;
    in_last  = hdr_push ? 1'b0 : rlast;
  end

  // Skid buffer next state: pop the head, then append any incoming word
  always_comb begin
    buf_n = buf_q;
    bl_n  = bl_q;
    cnt_n = cnt;
    if (fifo_pop) begin
      buf_n[0] = buf_q[1];
      bl_n[0]  = bl_q[1];
      cnt_n    = cnt - 2'd1;
    end
    if (in_vld) begin
      buf_n[cnt_n[0]] = in_data;
      bl_n[cnt_n[0]]  = in_last;
      cnt_n           = cnt_n + 2'd1;
    end
  end

  // Only issue a read when the buffer can absorb it even if the sink stalls
  assign issue = (state == S_STREAM) && (count != '0) &&
                 ((cnt == 2'd0) || ((cnt == 2'd1) && !rvld));

  // FSM state register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // FSM next state
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (start) state_nxt = (num_events != '0) ? S_FREEZE : S_DONE;
      S_FREEZE: state_nxt = S_SNAP;
      S_SNAP:   state_nxt = S_META;
      S_META:   state_nxt = S_STREAM;
      S_STREAM: if (last_hs) state_nxt = S_DONE;
      S_DONE:   state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // FSM outputs and memory read ports
  always_comb begin
    freeze               = 1'b0;
    busy                 = (state != S_IDLE);
    done                 = 1'b0;
    spy_meta_read_enable = 1'b0;
    spy_meta_read_addr   = '0;
    spy_read_enable      = issue;
    spy_read_addr        = rd;
    case (state)
      S_FREEZE: freeze = 1'b1;
      S_SNAP: begin
        freeze               = 1'b1;
        spy_meta_read_enable = 1'b1;
        spy_meta_read_addr   = spy_meta_write_addr - n_q;
      end
      S_META:   freeze = 1'b1;
      S_STREAM: freeze = 1'b1;
      S_DONE:   done   = 1'b1;
      default: ;
    endcase
  end

  // Datapath: request capture, pointer snapshot, read address/count, skid buffer
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      n_q   <= '0;
      wp_q  <= '0;
      rd    <= '0;
      count <= '0;
      rvld  <= 1'b0;
      rlast <= 1'b0;
      buf_q <= '0;
      bl_q  <= '0;
      cnt   <= '0;
    end else begin
      if (state == S_IDLE && start) n_q <= num_events;
      if (state == S_SNAP) wp_q <= spy_write_addr;
      if (state == S_META) begin
        rd    <= meta_rd;
        count <= meta_count;
      end else if (issue) begin
        rd    <= rd + RD_ONE;
        count <= count - CNT_ONE;
      end
      rvld  <= issue;
      rlast <= issue && (count == CNT_ONE);
      buf_q <= buf_n;
      bl_q  <= bl_n;
      cnt   <= cnt_n;
    end
  end

endmodule

// File: tb/tb_spy_readout.sv
// Bench for spy_readout: memory models, an expected-stream queue built from
// the dump rules, a per-cycle stream checker and directed timing checks.
module tb_spy_readout;
  localparam int DW = 64;
  localparam int SW = 7;
  localparam int EW = 4;
`ifdef SPY_READOUT_HEADER_EN
  localparam int HDR = 1;
`else
  localparam int HDR = 0;
`endif

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          start = 1'b0;
  logic [EW-1:0] num_events = '0;
  logic          freeze;
  logic [SW-1:0] spy_write_addr = '0;
  logic [EW-1:0] spy_meta_write_addr = '0;
  logic          spy_meta_read_enable;
  logic [EW-1:0] spy_meta_read_addr;
  logic [SW:0]   spy_meta_read_data = '0;
  logic          spy_read_enable;
  logic [SW-1:0] spy_read_addr;
  logic [DW:0]   spy_data = '0;
  logic [DW:0]   m_data;
  logic          m_valid;
  logic          m_ready = 1'b1;
  logic          m_last;
  logic          busy;
  logic          done;

  spy_readout #(.DATA_WIDTH(DW), .SPY_MEM_WIDTH(SW), .EL_MEM_WIDTH(EW)) dut (
    .clock(clock), .reset(reset), .start(start), .num_events(num_events),
    .freeze(freeze), .spy_write_addr(spy_write_addr),
    .spy_meta_write_addr(spy_meta_write_addr),
    .spy_meta_read_enable(spy_meta_read_enable),
    .spy_meta_read_addr(spy_meta_read_addr),
    .spy_meta_read_data(spy_meta_read_data),
    .spy_read_enable(spy_read_enable), .spy_read_addr(spy_read_addr),
    .spy_data(spy_data), .m_data(m_data), .m_valid(m_valid),
    .m_ready(m_ready), .m_last(m_last), .busy(busy), .done(done)
  );

  always #5 clock = ~clock;

  logic [DW:0] spy_mem  [128];
  logic [SW:0] meta_mem [16];

  // Memories with one cycle of registered read latency
  always @(posedge clock) begin
    if (spy_read_enable)      spy_data           <= spy_mem[spy_read_addr];
    if (spy_meta_read_enable) spy_meta_read_data <= meta_mem[spy_meta_read_addr];
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", name, got, exp);
    end
  endtask

  // Expected stream and bookkeeping
  logic [DW:0] expq[$];
  int          rx_cnt = 0;
  logic [DW:0] first_rx = '0;
  logic [DW:0] last_rx = '0;
  int          exp_sa = 0;
  int          exp_ma = 0;
  int          exp_total = 0;
  bit          bp_on = 1'b0;

  // Stall tracking for the hold-stable rules
  bit          stall_prev = 1'b0;
  logic [DW:0] stall_data = '0;
  logic        stall_last = 1'b0;
  logic [DW:0] e;

  // Stream checker: every handshake must match the next expected word
  always @(negedge clock) begin
    if (!reset) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        chk("hold_valid", m_valid, 1);
        chk("hold_data", m_data, stall_data);
        chk("hold_last", m_last, stall_last);
      end
      if (m_valid && m_ready) begin
        if (expq.size() == 0) begin
          chk("extra_word", m_valid & m_ready, 0);
        end else begin
          e = expq.pop_front();
          chk("stream_data", m_data, e);
          chk("stream_last", m_last, expq.size() == 0);
          if (rx_cnt == 0) first_rx = m_data;
          last_rx = m_data;
          rx_cnt++;
        end
      end
      stall_prev = m_valid && !m_ready;
      stall_data = m_data;
      stall_last = m_last;
    end
  end

  // Sink ready: held high, or toggled every cycle for backpressure
  initial begin
    forever begin
      @(posedge clock);
      #1;
      if (bp_on) m_ready = ~m_ready;
      else       m_ready = 1'b1;
    end
  end

  // Build the expected stream from the dump rules
  task automatic build_exp(input int n, input int wp, input int mp);
    logic [SW:0]  ent;
    logic [DW:0]  h;
    logic [EW-1:0] n4;
    logic [SW-1:0] sa7;
    logic [SW:0]   c8;
    int sa, cnt;
    expq.delete();
    rx_cnt = 0;
    exp_total = 0;
    spy_write_addr      = wp[SW-1:0];
    spy_meta_write_addr = mp[EW-1:0];
    if (n == 0) return;
    exp_ma = ((mp - n) % 16 + 16) % 16;
    ent = meta_mem[exp_ma];
    if (ent[SW]) begin
      sa  = int'(ent[SW-1:0]);
      cnt = ((wp - sa) % 128 + 128) % 128;
      if (cnt == 0) cnt = 128;
    end else begin
      sa  = wp;
      cnt = 128;
    end
    exp_sa = sa;
    if (HDR != 0) begin
      n4 = n[EW-1:0]; sa7 = sa[SW-1:0]; c8 = cnt[SW:0];
      h = '0;
      h[DW] = 1'b1;
      h[18:0] = {n4, sa7, c8};
      expq.push_back(h);
    end
    for (int i = 0; i < cnt; i++) expq.push_back(spy_mem[(sa + i) % 128]);
    exp_total = cnt + HDR;
  endtask

  task automatic kick(input int n);
    @(posedge clock); #1;
    start = 1'b1;
    num_events = n[EW-1:0];
    @(posedge clock); #1;
    start = 1'b0;
  endtask

  // Cycle-exact checks for cycles 1..5 after start
  task automatic check_timing();
    @(negedge clock);
    chk("c1_freeze", freeze, 1);
    chk("c1_busy", busy, 1);
    @(negedge clock);
    chk("c2_meta_en", spy_meta_read_enable, 1);
    chk("c2_meta_addr", spy_meta_read_addr, exp_ma);
    @(negedge clock);
    chk("c3_no_read", spy_read_enable, 0);
    chk("c3_no_valid", m_valid, 0);
    @(negedge clock);
    chk("c4_read_en", spy_read_enable, 1);
    chk("c4_read_addr", spy_read_addr, exp_sa);
    chk("c4_valid", m_valid, HDR);
    @(negedge clock);
    chk("c5_valid", m_valid, 1);
  endtask

  // Wait for done; freeze must hold until it, done follows the last handshake
  task automatic finish_dump(input bit inject);
    bit seen = 1'b0;
    bit prev_hs = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clock);
      if (inject && i == 1) begin start = 1'b1; num_events = 4'd5; end
      if (inject && i == 2) start = 1'b0;
      if (done) begin seen = 1'b1; break; end
      chk("freeze_held", freeze, 1);
      prev_hs = m_valid & m_ready & m_last;
    end
    chk("done_seen", seen, 1);
    if (seen) begin
      chk("done_after_last", prev_hs, 1);
      chk("freeze_at_done", freeze, 0);
      chk("busy_at_done", busy, 1);
      @(negedge clock);
      chk("busy_after_done", busy, 0);
      chk("done_pulse", done, 0);
    end
    chk("word_count", rx_cnt, exp_total);
    chk("queue_drained", expq.size(), 0);
  endtask

  initial begin
    logic [SW-1:0] a7;
    bit reached;
    for (int a = 0; a < 128; a++) begin
      a7 = a[SW-1:0];
      spy_mem[a] = {a7[0], 24'hC0FFEE, 33'h0, a7};
    end
    for (int a = 0; a < 16; a++) meta_mem[a] = '0;
    meta_mem[4]  = {1'b1, 7'd12};
    meta_mem[15] = {1'b1, 7'd120};
    meta_mem[9]  = '0;

    // Reset state
    repeat (2) @(negedge clock);
    chk("rst_freeze", freeze, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_valid", m_valid, 0);
    chk("rst_data", m_data, 0);
    chk("rst_last", m_last, 0);
    chk("rst_rd_en", spy_read_enable, 0);
    chk("rst_meta_en", spy_meta_read_enable, 0);
    chk("rst_rd_addr", spy_read_addr, 0);
    chk("rst_meta_addr", spy_meta_read_addr, 0);
    @(posedge clock); #1;
    reset = 1'b1;

    // Basic dump, with a start pulse during STREAM that must be ignored
    build_exp(1, 20, 5);
    chk("model_basic_len", exp_total, 8 + HDR);
    kick(1);
    check_timing();
    finish_dump(1'b1);
    chk("basic_last_addr", last_rx[6:0], 19);
    if (HDR != 0) chk("basic_header", first_rx, {1'b1, 45'h0, 19'h08C08});
    else          chk("basic_first_addr", first_rx[6:0], 12);
    repeat (3) begin
      @(negedge clock);
      chk("ignored_start_busy", busy, 0);
      chk("ignored_start_freeze", freeze, 0);
    end

    // Wrap through the top of spy memory (and of the event list)
    build_exp(3, 3, 2);
    chk("model_wrap_len", exp_total, 11 + HDR);
    kick(3);
    check_timing();
    finish_dump(1'b0);
    chk("wrap_last_addr", last_rx[6:0], 2);

    // Invalid entry: whole memory, oldest word first
    build_exp(1, 50, 10);
    chk("model_invalid_len", exp_total, 128 + HDR);
    kick(1);
    check_timing();
    finish_dump(1'b0);
    chk("invalid_last_addr", last_rx[6:0], 49);
    if (HDR == 0) chk("invalid_first_addr", first_rx[6:0], 50);

    // Backpressure: ready toggling every cycle
    bp_on = 1'b1;
    build_exp(1, 20, 5);
    kick(1);
    finish_dump(1'b0);
    chk("bp_last_addr", last_rx[6:0], 19);
    bp_on = 1'b0;

    // Zero events: done pulse only
    build_exp(0, 20, 5);
    kick(0);
    @(negedge clock);
    chk("zero_done", done, 1);
    chk("zero_freeze", freeze, 0);
    chk("zero_valid", m_valid, 0);
    @(negedge clock);
    chk("zero_busy", busy, 0);
    chk("zero_done_low", done, 0);
    chk("zero_valid2", m_valid, 0);

    // Reset mid-stream after three words, then a fresh dump
    build_exp(1, 20, 5);
    kick(1);
    reached = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clock);
      if (rx_cnt >= 3) begin reached = 1'b1; break; end
    end
    chk("mid_reached", reached, 1);
    #2 reset = 1'b0;
    #1;
    chk("mid_rst_freeze", freeze, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_valid", m_valid, 0);
    chk("mid_rst_last", m_last, 0);
    chk("mid_rst_data", m_data, 0);
    chk("mid_rst_rd_en", spy_read_enable, 0);
    expq.delete();
    @(negedge clock);
    chk("mid_rst_valid2", m_valid, 0);
    @(posedge clock); #1;
    reset = 1'b1;
    build_exp(1, 20, 5);
    kick(1);
    check_timing();
    finish_dump(1'b0);
    chk("fresh_last_addr", last_rx[6:0], 19);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
